// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_pkg
// Description : Shared types for the inter-stage pipeline register.
//               skid_state_t - occupancy state of the 2-entry skid buffer
//               occ_t        - entry count reported on the occupancy port
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

  typedef enum logic [1:0] {
    SK_EMPTY = 2'd0,
    SK_ONE   = 2'd1,
    SK_TWO   = 2'd2
  } skid_state_t;

  typedef logic [1:0] occ_t;

  // Number of valid entries held in each skid-buffer state.
  function automatic occ_t state_occ(input skid_state_t s);
    case (s)
      SK_ONE:  return 2'd1;
      SK_TWO:  return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_slot.sv
`default_nettype none
// ============================================================================
// Module      : pipe_slot
// Description : One pipeline entry: payload + control register with a valid
//               bit.
//   clk, rst    : clock (rising edge), asynchronous active-high reset
//   load_i      : capture data_i/ctrl_i and mark the entry valid
//   drop_i      : mark the entry invalid (payload/control left as is)
//   kill_i      : flush - entry invalid, control zeroed; wins over load_i
//   clr_data_i  : with kill_i, also zero the payload
//   data_i/ctrl_i : incoming payload / control
//   valid_o, data_o, ctrl_o : held entry
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_slot #(
  parameter int DATA_W = 128,
  parameter int CTRL_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              drop_i,
  input  logic              kill_i,
  input  logic              clr_data_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic [CTRL_W-1:0] ctrl_o
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q,  data_d;
  logic [CTRL_W-1:0] ctrl_q,  ctrl_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    ctrl_d  = ctrl_q;
    if (kill_i) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
      if (clr_data_i) begin
        data_d = '0;
      end
    end else if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
      ctrl_d  = ctrl_i;
    end else if (drop_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      ctrl_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign ctrl_o  = ctrl_q;

endmodule
`default_nettype wire

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_reg
// Description : Parametrised inter-stage pipeline register with valid/ready
//               handshake, flush (bubble insertion) and optional 2-entry
//               skid buffer that registers the upstream ready.
//   CLK, RST            : clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready   : upstream handshake
//   in_data/in_ctrl     : upstream payload / control bundle
//   flush               : synchronous kill of all held entries
//   out_valid/out_ready : downstream handshake
//   out_data/out_ctrl   : head entry; out_ctrl is 0 whenever out_valid is 0
//   occupancy           : number of entries held
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W            = 128,
  parameter int CTRL_W            = 16,
  parameter int SKID              = 1,
  parameter int CLR_DATA_ON_FLUSH = 0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output occ_t              occupancy
);

  logic              w_push;
  logic              w_pop;
  logic              w_clr_data;
  logic              w_main_load;
  logic              w_main_drop;
  logic [DATA_W-1:0] w_main_data_in;
  logic [CTRL_W-1:0] w_main_ctrl_in;
  logic              w_main_valid;
  logic [DATA_W-1:0] w_main_data;
  logic [CTRL_W-1:0] w_main_ctrl;

  assign w_push     = in_valid & in_ready;
  assign w_pop      = w_main_valid & out_ready;
  assign w_clr_data = flush & (CLR_DATA_ON_FLUSH != 0);

  // The main slot is always the head of the queue.
  pipe_slot #(
    .DATA_W (DATA_W),
    .CTRL_W (CTRL_W)
  ) u_main (
    .clk        (CLK),
    .rst        (RST),
    .load_i     (w_main_load),
    .drop_i     (w_main_drop),
    .kill_i     (flush),
    .clr_data_i (w_clr_data),
    .data_i     (w_main_data_in),
    .ctrl_i     (w_main_ctrl_in),
    .valid_o    (w_main_valid),
    .data_o     (w_main_data),
    .ctrl_o     (w_main_ctrl)
  );

  generate
    if (SKID == 0) begin : g_single
      // Ready follows downstream combinationally: free, or being emptied now.
      assign in_ready       = out_ready | ~w_main_valid;
      assign w_main_load    = w_push & ~flush;
      assign w_main_drop    = w_pop & ~w_push;
      assign w_main_data_in = in_data;
      assign w_main_ctrl_in = in_ctrl;
      assign occupancy      = {1'b0, w_main_valid};
    end else begin : g_skid
      skid_state_t       state_q, state_d;
      logic              skid_load;
      logic              skid_drop;
      logic              main_sel_skid;
      logic              skid_valid;
      logic [DATA_W-1:0] skid_data;
      logic [CTRL_W-1:0] skid_ctrl;

      pipe_slot #(
        .DATA_W (DATA_W),
        .CTRL_W (CTRL_W)
      ) u_skid (
        .clk        (CLK),
        .rst        (RST),
        .load_i     (skid_load),
        .drop_i     (skid_drop),
        .kill_i     (flush),
        .clr_data_i (w_clr_data),
        .data_i     (in_data),
        .ctrl_i     (in_ctrl),
        .valid_o    (skid_valid),
        .data_o     (skid_data),
        .ctrl_o     (skid_ctrl)
      );

      always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
          state_q <= SK_EMPTY;
        end else begin
          state_q <= state_d;
        end
      end

      always_comb begin
        state_d       = state_q;
        w_main_load   = 1'b0;
        w_main_drop   = 1'b0;
        main_sel_skid = 1'b0;
        skid_load     = 1'b0;
        skid_drop     = 1'b0;
        if (flush) begin
          // Slots are killed directly; a push this cycle is discarded.
          state_d = SK_EMPTY;
        end else begin
          case (state_q)
            SK_EMPTY: begin
              if (w_push) begin
                state_d     = SK_ONE;
                w_main_load = 1'b1;
              end
            end
            SK_ONE: begin
              if (w_push && w_pop) begin
                w_main_load = 1'b1;
              end else if (w_push) begin
                state_d   = SK_TWO;
                skid_load = 1'b1;
              end else if (w_pop) begin
                state_d     = SK_EMPTY;
                w_main_drop = 1'b1;
              end
            end
            SK_TWO: begin
              // in_ready is low here, so only a pop can occur.
              if (w_pop) begin
                state_d       = SK_ONE;
                w_main_load   = 1'b1;
                main_sel_skid = 1'b1;
                skid_drop     = 1'b1;
              end
            end
            default: state_d = SK_EMPTY;
          endcase
        end
      end

      // Derived from the state register only: no path from out_ready.
      assign in_ready       = (state_q != SK_TWO);
      assign w_main_data_in = main_sel_skid ? skid_data : in_data;
      assign w_main_ctrl_in = main_sel_skid ? skid_ctrl : in_ctrl;
      assign occupancy      = skid_valid ? state_occ(SK_TWO) : state_occ(state_q);
    end
  endgenerate

  assign out_valid = w_main_valid;
  assign out_data  = w_main_data;
  // Bubbles never carry live control.
  assign out_ctrl  = w_main_valid ? w_main_ctrl : '0;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_stage_reg
// Description : Directed self-checking bench for pipe_stage_reg. Two SKID=1
//               instances (payload kept / zeroed on flush) share stimulus; a
//               SKID=0 instance has its own stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_reg;
  import pipe_pkg::*;

  localparam int DW = 32;
  localparam int CW = 16;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  // shared stimulus for the SKID=1 pair
  logic          s_in_valid = 1'b0;
  logic [DW-1:0] s_in_data  = '0;
  logic [CW-1:0] s_in_ctrl  = '0;
  logic          s_flush    = 1'b0;
  logic          s_out_ready = 1'b0;

  logic          a_in_ready, a_out_valid;
  logic [DW-1:0] a_out_data;
  logic [CW-1:0] a_out_ctrl;
  occ_t          a_occ;
  logic          b_in_ready, b_out_valid;
  logic [DW-1:0] b_out_data;
  logic [CW-1:0] b_out_ctrl;
  occ_t          b_occ;

  // SKID=0 instance
  logic          c_in_valid = 1'b0;
  logic [DW-1:0] c_in_data  = '0;
  logic [CW-1:0] c_in_ctrl  = '0;
  logic          c_flush    = 1'b0;
  logic          c_out_ready = 1'b0;
  logic          c_in_ready, c_out_valid;
  logic [DW-1:0] c_out_data;
  logic [CW-1:0] c_out_ctrl;
  occ_t          c_occ;

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(1), .CLR_DATA_ON_FLUSH(0)) u_dut_a (
    .CLK(CLK), .RST(RST), .in_valid(s_in_valid), .in_ready(a_in_ready),
    .in_data(s_in_data), .in_ctrl(s_in_ctrl), .flush(s_flush),
    .out_valid(a_out_valid), .out_ready(s_out_ready), .out_data(a_out_data),
    .out_ctrl(a_out_ctrl), .occupancy(a_occ));

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(1), .CLR_DATA_ON_FLUSH(1)) u_dut_b (
    .CLK(CLK), .RST(RST), .in_valid(s_in_valid), .in_ready(b_in_ready),
    .in_data(s_in_data), .in_ctrl(s_in_ctrl), .flush(s_flush),
    .out_valid(b_out_valid), .out_ready(s_out_ready), .out_data(b_out_data),
    .out_ctrl(b_out_ctrl), .occupancy(b_occ));

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(0), .CLR_DATA_ON_FLUSH(0)) u_dut_c (
    .CLK(CLK), .RST(RST), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .in_data(c_in_data), .in_ctrl(c_in_ctrl), .flush(c_flush),
    .out_valid(c_out_valid), .out_ready(c_out_ready), .out_data(c_out_data),
    .out_ctrl(c_out_ctrl), .occupancy(c_occ));

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // advance one clock; return 1 time unit after the rising edge
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic s_drive(input logic v, input logic [DW-1:0] d, input logic [CW-1:0] c,
                         input logic rdy, input logic fl);
    s_in_valid  = v;
    s_in_data   = d;
    s_in_ctrl   = c;
    s_out_ready = rdy;
    s_flush     = fl;
  endtask

  task automatic c_drive(input logic v, input logic [DW-1:0] d, input logic [CW-1:0] c,
                         input logic rdy, input logic fl);
    c_in_valid  = v;
    c_in_data   = d;
    c_in_ctrl   = c;
    c_out_ready = rdy;
    c_flush     = fl;
  endtask

  initial begin
    step();
    step();
    RST = 1'b0;

    // ---------------- reset state ----------------
    check("rst_a_valid", a_out_valid, 0);
    check("rst_a_occ",   a_occ, 0);
    check("rst_a_ready", a_in_ready, 1);
    check("rst_a_ctrl",  a_out_ctrl, 0);
    check("rst_c_ready", c_in_ready, 1);
    check("rst_c_occ",   c_occ, 0);

    // ---------------- streaming, SKID=1 ----------------
    s_drive(1, 32'h10, 16'h0001, 1, 0);
    step();
    check("stream0_data", a_out_data, 32'h10);
    check("stream0_occ",  a_occ, 1);
    s_drive(1, 32'h11, 16'h0002, 1, 0);
    step();
    check("stream1_data", a_out_data, 32'h11);
    check("stream1_ctrl", a_out_ctrl, 16'h0002);
    check("stream1_occ",  a_occ, 1);
    s_drive(1, 32'h12, 16'h0003, 1, 0);
    step();
    check("stream2_data", a_out_data, 32'h12);
    check("stream2_occ",  a_occ, 1);
    s_drive(0, 32'h0, 16'h0, 1, 0);
    step();
    check("stream_drain_valid", a_out_valid, 0);
    check("stream_drain_occ",   a_occ, 0);

    // ---------------- backpressure, SKID=1 ----------------
    s_drive(1, 32'hA0, 16'h00FF, 0, 0);
    step();
    check("bp0_occ",   a_occ, 1);
    check("bp0_ready", a_in_ready, 1);
    s_drive(1, 32'hA1, 16'h00FE, 0, 0);
    step();
    check("bp1_occ",   a_occ, 2);
    check("bp1_ready", a_in_ready, 0);
    check("bp1_head",  a_out_data, 32'hA0);
    s_drive(0, 32'h0, 16'h0, 1, 0);
    #1;
    check("bp_ready_registered", a_in_ready, 0);
    step();
    check("bp_pop0_data",  a_out_data, 32'hA1);
    check("bp_pop0_ctrl",  a_out_ctrl, 16'h00FE);
    check("bp_pop0_occ",   a_occ, 1);
    check("bp_pop0_ready", a_in_ready, 1);
    step();
    check("bp_pop1_valid", a_out_valid, 0);
    check("bp_pop1_occ",   a_occ, 0);

    // ---------------- flush with two entries ----------------
    s_drive(1, 32'hC0, 16'h00FF, 0, 0);
    step();
    s_drive(1, 32'hC1, 16'h00FF, 0, 0);
    step();
    check("fl2_pre_occ", a_occ, 2);
    s_drive(1, 32'hB0, 16'h00FF, 0, 1);
    step();
    s_drive(0, 32'h0, 16'h0, 0, 0);
    check("fl2_a_valid", a_out_valid, 0);
    check("fl2_a_ctrl",  a_out_ctrl, 0);
    check("fl2_a_occ",   a_occ, 0);
    check("fl2_a_data_kept", a_out_data, 32'hC0);
    check("fl2_b_data_zero", b_out_data, 0);
    check("fl2_b_occ",   b_occ, 0);
    step();
    check("fl2_after_valid", a_out_valid, 0);

    // ---------------- flush with one entry and a real push ----------------
    s_drive(1, 32'hD0, 16'h0F0F, 0, 0);
    step();
    check("fl1_pre_occ", a_occ, 1);
    s_drive(1, 32'hB1, 16'h00FF, 0, 1);
    step();
    s_drive(0, 32'h0, 16'h0, 1, 0);
    check("fl1_occ",   a_occ, 0);
    check("fl1_valid", a_out_valid, 0);
    check("fl1_ready", a_in_ready, 1);
    check("fl1_a_data_no_push", a_out_data, 32'hD0);
    check("fl1_b_data_zero", b_out_data, 0);
    step();
    check("fl1_after_valid", a_out_valid, 0);

    // ---------------- bubble gating ----------------
    for (int i = 0; i < 3; i++) begin
      s_drive(0, 32'h5A5A, 16'hFFFF, 1, 0);
      step();
      check("bubble_ctrl",  a_out_ctrl, 0);
      check("bubble_valid", a_out_valid, 0);
    end

    // ---------------- async reset with two entries ----------------
    s_drive(1, 32'hE0, 16'h1234, 0, 0);
    step();
    s_drive(1, 32'hE1, 16'h1234, 0, 0);
    step();
    check("rst2_pre_occ", a_occ, 2);
    #2;
    RST = 1'b1;
    #1;
    check("rst2_valid", a_out_valid, 0);
    check("rst2_ctrl",  a_out_ctrl, 0);
    check("rst2_occ",   a_occ, 0);
    s_drive(0, 32'h0, 16'h0, 0, 0);
    step();
    RST = 1'b0;
    step();
    check("rst2_ready", a_in_ready, 1);
    check("rst2_occ_after", a_occ, 0);

    // ---------------- SKID=0 stall / release ----------------
    c_drive(1, 32'h50, 16'h0011, 0, 0);
    #1;
    check("s0_ready_empty", c_in_ready, 1);
    step();
    check("s0_load_data",  c_out_data, 32'h50);
    check("s0_load_valid", c_out_valid, 1);
    check("s0_load_occ",   c_occ, 1);
    c_drive(1, 32'h51, 16'h0022, 0, 0);
    #1;
    check("s0_stall_ready", c_in_ready, 0);
    step();
    check("s0_stall_data", c_out_data, 32'h50);
    check("s0_stall_ctrl", c_out_ctrl, 16'h0011);
    c_out_ready = 1'b1;
    #1;
    check("s0_release_ready", c_in_ready, 1);
    step();
    check("s0_new_data", c_out_data, 32'h51);
    check("s0_new_ctrl", c_out_ctrl, 16'h0022);
    c_drive(0, 32'h0, 16'hFFFF, 1, 0);
    step();
    check("s0_drain_valid", c_out_valid, 0);
    check("s0_drain_ctrl",  c_out_ctrl, 0);
    check("s0_drain_occ",   c_occ, 0);

    // ---------------- SKID=0 flush with push ----------------
    c_drive(1, 32'h60, 16'h0033, 0, 0);
    step();
    c_drive(1, 32'h61, 16'h0044, 1, 1);
    step();
    c_drive(0, 32'h0, 16'h0, 1, 0);
    check("s0_flush_valid", c_out_valid, 0);
    check("s0_flush_ctrl",  c_out_ctrl, 0);
    check("s0_flush_data",  c_out_data, 32'h60);
    step();
    check("s0_flush_after", c_out_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Parametrised inter-stage pipeline register for the dual-core datapath. It is the generalised successor to the fixed IF/ID, ID/EX, EX/MEM and MEM/WB latches.
- Carries an opaque data bundle plus a control bundle under a valid/ready handshake.
- Control is zeroed on flush (bubble insertion).
- Optional 2-entry skid buffer breaks the combinational ready path between stages.
- Instantiated once per stage boundary, per core.

Parameters:
DATA_W, 128, width of payload bundle (pc, instr, operands, imm); held on stall, not cleared on flush.
CTRL_W, 16, width of control bundle (RegWr, MemWr, MemRead, halt, atomic, ...); forced to 0 on flush and whenever out_valid=0.
SKID, 1, 0 = single register with combinational ready; 1 = 2-entry skid buffer with registered ready.
CLR_DATA_ON_FLUSH, 0, 1 = payload also zeroed on flush.

Ports:
CLK  in  1  clock, rising edge
RST  in  1  asynchronous reset, active-high
in_valid  in  1  upstream stage holds valid content
in_ready  out  1  this stage accepts in_data/in_ctrl this cycle
in_data  in  DATA_W  upstream payload
in_ctrl  in  CTRL_W  upstream control
flush  in  1  synchronous kill of all held entries (branch/jump mispredict, hazard unit)
out_valid  out  1  downstream-facing entry valid
out_ready  in  1  downstream accepts this cycle
out_data  out  DATA_W  head payload
out_ctrl  out  CTRL_W  head control; 0 when out_valid=0
occupancy  out  2  entries held (0..1 for SKID=0, 0..2 for SKID=1)

Behaviour:
- Transfers: push = in_valid & in_ready; pop = out_valid & out_ready.
- Reset (RST high, async): all valid bits 0, data/ctrl registers 0, occupancy 0, out_valid 0, in_ready 1 (SKID=1); SKID=0 in_ready = 1 because out_valid=0. Reset mid-transfer drops everything; no partial entries.
- SKID=0:
  - in_ready = out_ready | ~out_valid (combinational).
  - On push, load main slot next edge.
  - On pop without push, clear valid.
  - Stall (out_valid & ~out_ready) holds data/ctrl unchanged.
  - Latency 1 cycle.
- SKID=1 FSM (state enum in package):
  - SK_EMPTY -> SK_ONE on push.
  - SK_ONE: push&pop stays SK_ONE, main reloads. Push&~pop -> SK_TWO, new entry into skid slot. Pop&~push -> SK_EMPTY.
  - SK_TWO: in_ready=0. Pop -> SK_ONE, skid slot moves to main.
  - in_ready = (state != SK_TWO), registered; no combinational path from out_ready to in_ready.
  - Latency 1 cycle when empty; order strictly FIFO.
- Flush (priority over everything but RST):
  - Next state SK_EMPTY, all valid 0, ctrl registers 0.
  - Payload zeroed only if CLR_DATA_ON_FLUSH=1.
  - A push in the flush cycle is discarded.
  - A pop in the flush cycle is still honoured downstream (data was presented), but the entry is not retained.
- out_ctrl = valid ? ctrl_reg : 0. Guarantees bubbles never write registers/memory.
- occupancy = number of valid slots, updated with state.
- No width arithmetic; all bundles pass bit-exact.

Decomposition:
- Shared package pipe_pkg: skid_state_t {SK_EMPTY, SK_ONE, SK_TWO} (2-bit), occupancy type occ_t (2-bit).
- Per-stage bundle widths are defined in cpu_types_pkg, not here.
- One natural sub-module: pipe_slot (one DATA_W+CTRL_W register with valid, load, clear-ctrl, clear-data controls).
  - Instantiated once for the main slot.
  - Instantiated once more for the skid slot under generate SKID=1.

Test Plan:
- Reset: assert RST mid-cycle with occupancy=2 -> immediately out_valid=0, out_ctrl=0, occupancy=0; after release in_ready=1.
- Streaming SKID=1: in_valid=1, out_ready=1, data 0x10,0x11,0x12 on consecutive cycles -> out_data 0x10,0x11,0x12 one cycle later each, occupancy stays 1.
- Backpressure SKID=1: push 0xA0, 0xA1 with out_ready=0 -> occupancy=2, in_ready=0 next cycle. Release out_ready -> 0xA0 then 0xA1 in order, in_ready=1 after first pop.
- Flush: occupancy=2, ctrl=0x00FF, flush=1 with simultaneous push of 0xB0 -> next cycle out_valid=0, out_ctrl=0, occupancy=0. 0xB0 never appears. Payload retained with CLR_DATA_ON_FLUSH=0, zeroed with CLR_DATA_ON_FLUSH=1.
- SKID=0 stall: out_valid=1, out_ready=0, in_valid=1 -> in_ready=0 same cycle, out_data stable. Set out_ready=1 -> in_ready=1 combinationally, new data appears next cycle.
- Bubble gating: in_valid=0 with in_ctrl=0xFFFF for 3 cycles -> out_ctrl stays 0 and out_valid stays 0 throughout.
